// File: rtl/cp_strip_if.sv
// Stream bundle around the cyclic-prefix stripper: time-domain input beats in,
// FFT-length output beats out. The slave modport is the stripper's view.
interface cp_strip_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tuser;
  logic              m_tlast;

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
  );

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
  );
endinterface

// File: rtl/cp_strip.sv
// Cyclic-prefix stripper: drops cp_len samples per OFDM symbol and forwards fft_len
// samples with first/last markers, behind a one-deep output register.
module cp_strip #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SYM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tready_global,
  input  logic                 config_update,
  input  logic [12:0]          fft_len_in,
  input  logic [8:0]           cp_len_in,
  cp_strip_if.slave            bus,
  output logic [SYM_CNT_W-1:0] sym_cnt,
  output logic                 cfg_err
);

  typedef enum logic [0:0] {StCp, StData} state_e;

  state_e               state_q, state_d;
  logic [12:0]          cnt_q, cnt_d;
  logic [12:0]          fft_len_q, fft_len_d;
  logic [8:0]           cp_len_q, cp_len_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [DATA_W-1:0]    m_tdata_q, m_tdata_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tuser_q, m_tuser_d;
  logic                 m_tlast_q, m_tlast_d;

  logic                 cfg_legal;
  logic                 s_tready;
  logic                 accept;
  logic                 load;
  logic                 cp_done;
  logic                 sym_done;

  assign cfg_legal = (fft_len_in != 13'd0) && ({4'd0, cp_len_in} < fft_len_in);

  // The config cycle never accepts a beat, so the new geometry starts on a clean boundary.
  always_comb begin
    s_tready = 1'b0;
    if (!config_update) begin
      if (state_q == StCp) begin
        s_tready = tready_global;
      end else begin
        s_tready = tready_global && (!m_tvalid_q || bus.m_tready);
      end
    end
  end

  assign accept   = bus.s_tvalid && s_tready;
  assign load     = accept && (state_q == StData);
  assign cp_done  = (cnt_q == ({4'd0, cp_len_q} - 13'd1));
  assign sym_done = (cnt_q == (fft_len_q - 13'd1));

  // Phase/counter next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fft_len_d = fft_len_q;
    cp_len_d  = cp_len_q;
    sym_cnt_d = sym_cnt_q;
    cfg_err_d = 1'b0;

    if (config_update) begin
      if (cfg_legal) begin
        fft_len_d = fft_len_in;
        cp_len_d  = cp_len_in;
        cnt_d     = 13'd0;
        sym_cnt_d = '0;
        state_d   = (cp_len_in == 9'd0) ? StData : StCp;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (accept) begin
      unique case (state_q)
        StCp: begin
          if (cp_done) begin
            state_d = StData;
            cnt_d   = 13'd0;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
        StData: begin
          if (sym_done) begin
            cnt_d     = 13'd0;
            sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
            state_d   = (cp_len_q == 9'd0) ? StData : StCp;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
        default: begin
          state_d = StCp;
          cnt_d   = 13'd0;
        end
      endcase
    end
  end

  // Output register: a drain and a load in the same cycle keeps valid high with new data.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    if (load) begin
      m_tdata_d  = bus.s_tdata;
      m_tuser_d  = (cnt_q == 13'd0);
      m_tlast_d  = sym_done;
      m_tvalid_d = 1'b1;
    end else if (m_tvalid_q && bus.m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StCp;
      cnt_q     <= 13'd0;
      fft_len_q <= 13'd2048;
      cp_len_q  <= 9'd144;
      sym_cnt_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fft_len_q <= fft_len_d;
      cp_len_q  <= cp_len_d;
      sym_cnt_q <= sym_cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign bus.s_tready = s_tready;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tuser  = m_tuser_q;
  assign bus.m_tlast  = m_tlast_q;
  assign sym_cnt      = sym_cnt_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_cp_strip.sv
// Directed bench for cp_strip: ramp stimulus, scoreboard queue of expected output beats.
module tb_cp_strip;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tready_global;
  logic        config_update;
  logic [12:0] fft_len_in;
  logic [8:0]  cp_len_in;
  logic [15:0] sym_cnt;
  logic        cfg_err;

  cp_strip_if #(.DATA_W(32)) bus ();

  cp_strip #(.DATA_W(32), .SYM_CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .tready_global (tready_global),
    .config_update (config_update),
    .fft_len_in    (fft_len_in),
    .cp_len_in     (cp_len_in),
    .bus           (bus),
    .sym_cnt       (sym_cnt),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  int          mfft, mcp, mcnt, msym;
  bit          mphase;
  bit          toggle_rdy;
  int unsigned next_sample;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mfft = 2048; mcp = 144; mcnt = 0; msym = 0; mphase = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [31:0] d);
    beat_t b;
    if (!mphase) begin
      mcnt++;
      if (mcnt == mcp) begin mphase = 1; mcnt = 0; end
    end else begin
      b.d = d; b.u = (mcnt == 0); b.l = (mcnt == mfft - 1);
      exp_q.push_back(b);
      if (mcnt == mfft - 1) begin
        mcnt = 0; msym = (msym + 1) % 65536; mphase = (mcp == 0);
      end else begin
        mcnt++;
      end
    end
  endtask

  // Offers ramp samples until n are accepted; the caller must drive the very next cycle.
  task automatic send(input int n);
    int got = 0;
    int guard = 0;
    while (got < n) begin
      @(posedge clk); #1;
      bus.m_tready = toggle_rdy ? ~bus.m_tready : 1'b1;
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = next_sample;
      #1;
      if (bus.s_tready) begin
        model_accept(next_sample);
        next_sample++;
        got++;
      end
      guard++;
      if (guard > 4 * n + 100) begin
        check("send_timeout", got, n);
        break;
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b1;
    while (exp_q.size() > 0 && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic cfg(input int fft, input int cp, input logic rdy);
    bit legal;
    legal = (fft != 0) && (cp < fft);
    @(posedge clk); #1;
    toggle_rdy    = 0;
    bus.s_tvalid  = 1'b1;
    bus.m_tready  = rdy;
    config_update = 1'b1;
    fft_len_in    = fft[12:0];
    cp_len_in     = cp[8:0];
    #1;
    check("s_tready_in_cfg_cycle", bus.s_tready, 0);
    @(posedge clk); #1;
    config_update = 1'b0;
    bus.s_tvalid  = 1'b0;
    bus.m_tready  = 1'b1;
    if (legal) begin
      mfft = fft; mcp = cp; mcnt = 0; msym = 0; mphase = (cp == 0);
    end
    check("cfg_err_pulse", cfg_err, !legal);
    check("sym_cnt_after_cfg", sym_cnt, msym);
    @(posedge clk); #1;
    check("cfg_err_clear", cfg_err, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, bus.m_tvalid, 0);
    check({tag, "_m_tdata"}, bus.m_tdata, 0);
    check({tag, "_m_tuser"}, bus.m_tuser, 0);
    check({tag, "_m_tlast"}, bus.m_tlast, 0);
    check({tag, "_sym_cnt"}, sym_cnt, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // Scoreboard pop plus hold-while-stalled check, sampled mid-cycle
  bit          stall_q = 0;
  logic [33:0] held;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        check("stall_valid_held", bus.m_tvalid, 1);
        check("stall_data_held", {bus.m_tdata, bus.m_tuser, bus.m_tlast}, held);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", bus.m_tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          check("m_tdata", bus.m_tdata, e.d);
          check("m_tuser", bus.m_tuser, e.u);
          check("m_tlast", bus.m_tlast, e.l);
        end
      end
      stall_q = bus.m_tvalid && !bus.m_tready;
      held    = {bus.m_tdata, bus.m_tuser, bus.m_tlast};
    end
  end

  initial begin
    rst = 1'b1;
    tready_global = 1'b1;
    config_update = 1'b0;
    fft_len_in = '0;
    cp_len_in = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata = '0;
    bus.m_tready = 1'b1;
    toggle_rdy = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Default geometry 2048/144
    next_sample = 0;
    send(2192);
    drain();
    check("sym_cnt_default", sym_cnt, 1);

    // 256/32, two symbols back to back
    cfg(256, 32, 1'b1);
    next_sample = 0;
    send(576);
    drain();
    check("sym_cnt_256", sym_cnt, 2);

    // Back-pressure toggling every cycle
    toggle_rdy = 1;
    next_sample = 0;
    send(288);
    toggle_rdy = 0;
    drain();

    // Global pause mid-data
    next_sample = 0;
    send(82);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tready_global = 1'b0;
      bus.s_tvalid  = 1'b1;
      bus.s_tdata   = next_sample;
      #1;
      check("s_tready_paused", bus.s_tready, 0);
    end
    @(posedge clk); #1;
    tready_global = 1'b1;
    bus.s_tvalid  = 1'b0;
    send(206);
    drain();
    check("sym_cnt_after_pause", sym_cnt, 4);

    // Abort a 2048 symbol after 100 data beats, output held pending across the config
    cfg(2048, 144, 1'b1);
    next_sample = 0;
    send(244);
    cfg(2048, 144, 1'b0);
    drain();
    check("sym_cnt_after_abort", sym_cnt, 0);
    next_sample = 0;
    send(2192);
    drain();
    check("sym_cnt_post_abort", sym_cnt, 1);

    // Illegal configs keep 2048/144
    cfg(256, 300, 1'b1);
    cfg(256, 256, 1'b1);
    cfg(0, 0, 1'b1);
    next_sample = 0;
    send(2192);
    drain();
    check("sym_cnt_retained", sym_cnt, 2);

    // No cyclic prefix
    cfg(4096, 0, 1'b1);
    next_sample = 100;
    send(4096);
    drain();
    check("sym_cnt_4096", sym_cnt, 1);

    // Reset mid-data while an output beat is pending
    next_sample = 0;
    send(10);
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_data");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.m_tready = 1'b1;
    next_sample = 0;
    send(2192);
    drain();
    check("sym_cnt_after_rst_data", sym_cnt, 1);

    // Reset mid-prefix
    next_sample = 0;
    send(50);
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_cp");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    next_sample = 0;
    send(2192);
    drain();
    check("sym_cnt_after_rst_cp", sym_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp_strip.md
Name: cp_strip

Overview:
- Sits directly downstream of the receiver mode controller and upstream of the FFT operator.
- Takes a continuous AXI-Stream of time-domain IQ samples, discards the cyclic prefix of each OFDM symbol, and forwards exactly fft_len samples per symbol with start/end-of-symbol markers.
- Holds shadow copies of fft_len/cp_len, loaded only on the controller's config_update pulse; honours the controller's global pause (tready_global).

Parameters:
DATA_W, 32, sample width (I in upper half, Q in lower half); passed through unmodified
SYM_CNT_W, 16, width of symbol counter output

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tready_global  in  1  1=run, 0=pause input acceptance
config_update  in  1  single-cycle pulse: load fft_len_in/cp_len_in into shadow regs
fft_len_in  in  13  requested FFT length (samples)
cp_len_in  in  9  requested CP length (samples)
s_tdata  in  DATA_W  input sample
s_tvalid  in  1  input valid
s_tready  out  1  input ready
m_tdata  out  DATA_W  output sample
m_tvalid  out  1  output valid
m_tready  in  1  output ready
m_tuser  out  1  first useful sample of symbol
m_tlast  out  1  last sample of symbol
sym_cnt  out  SYM_CNT_W  completed symbols since reset/config, wraps
cfg_err  out  1  one-cycle pulse: config rejected

Behaviour:
- Reset values: shadow fft_len=2048, cp_len=144; state=S_CP, cnt=0; m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0; sym_cnt=0; cfg_err=0. Reset mid-symbol discards all partial state; first beat after reset is CP sample 0.
- Beat accepted = s_tvalid && s_tready.
- States: S_CP (discard), S_DATA (forward). cnt is 13-bit, counts accepted beats within the current phase.
- s_tready: 0 during the config_update cycle; otherwise in S_CP = tready_global; in S_DATA = tready_global && (!m_tvalid || m_tready).
- S_CP: each accepted beat is dropped and increments cnt; the beat with cnt==cp_len-1 moves to S_DATA with cnt=0. If cp_len==0, S_CP is never occupied (entry goes straight to S_DATA).
- S_DATA: each accepted beat loads the output register next cycle (latency 1 cycle): m_tdata=s_tdata, m_tuser=(cnt==0), m_tlast=(cnt==fft_len-1). On the last beat, sym_cnt increments (mod 2^SYM_CNT_W), cnt=0, and the state goes to S_CP (S_DATA if cp_len==0).
- Output register: m_tvalid set on load, cleared when m_tvalid && m_tready and no new load. A simultaneous drain and load keeps m_tvalid=1 with the new data. m_tdata/m_tuser/m_tlast hold stable while m_tvalid && !m_tready.
- tready_global=0: no input accepted; a pending output beat still drains to m_tready; counters frozen.
- config_update=1 (legal config): shadow regs take fft_len_in/cp_len_in; state forced to S_CP (or S_DATA if the new cp_len==0); cnt=0; sym_cnt=0. A pending output beat is kept and drains normally. A partial symbol is aborted: no tlast is emitted for it.
- Illegal config: fft_len_in==0, or cp_len_in>=fft_len_in. The shadow regs, state, counters and sym_cnt are unchanged. cfg_err pulses high for 1 cycle, the cycle after config_update.
- config_update takes priority over a beat in the same cycle; s_tready=0, so none is accepted.

Test Plan:
- Reset defaults, continuous ramp s_tdata=0..2191, m_tready=1 -> 2048 output beats of data 144..2191; m_tuser on 144, m_tlast on 2191; sym_cnt=1.
- config_update with 256/32, then 2×288-sample ramp -> per symbol data 32..287 forwarded, tuser/tlast at the first/last; sym_cnt=2; then m_tready toggled 1/0 each cycle -> no loss or duplication, data stable while stalled.
- tready_global=0 for 20 cycles mid-S_DATA with s_tvalid=1 -> s_tready=0, no beats consumed, cnt frozen; resumes at the exact next sample.
- config_update after 100 data beats of a 2048 symbol -> no tlast for the aborted symbol, pending beat drains, next accepted beat is CP sample 0 of the new config; sym_cnt=0.
- config fft_len_in=256, cp_len_in=300 -> cfg_err pulse, old 2048/144 retained. Config 4096/0 -> no CP dropped, tuser on the first beat, tlast on beat 4095.
- Assert rst mid-S_CP and mid-S_DATA -> all outputs return to reset values immediately, shadow regs = 2048/144.
